// File: rtl/score_display_driver_if.sv
// rtl/score_display_driver_if.sv - digit inputs and seven-segment outputs of the score display driver
interface score_display_driver_if;
    logic [3:0] thousands;
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] ones;
    logic       blank_lz;
    logic       blink_en;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       frame_done;

    modport master (
        output thousands, hundreds, tens, ones, blank_lz, blink_en,
        input  an, seg, dp, frame_done
    );

    modport slave (
        input  thousands, hundreds, tens, ones, blank_lz, blink_en,
        output an, seg, dp, frame_done
    );
endinterface

// File: rtl/score_display_driver.sv
// rtl/score_display_driver.sv - 4-digit multiplexed seven-segment driver with frame capture, zero blanking and blink
module score_display_driver #(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLINK_FRAMES = 125
) (
    input  logic                   clk,
    input  logic                   rst_n,
    score_display_driver_if.slave  bus
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_FRAMES - 1);

    typedef enum logic {IDLE, SCAN} state_t;

    state_t          state;
    logic [PW-1:0]   presc;
    logic [1:0]      slot;
    logic [3:0][3:0] shadow;       // index 0 = ones ... 3 = thousands
    logic [BW-1:0]   blink_cnt;
    logic            blink_phase;
    logic [3:0]      an_q;
    logic [6:0]      seg_q;
    logic            frame_done_q;

    logic            tick;
    logic            wrap;
    logic            capture;
    logic            nxt_scan;
    logic [1:0]      nxt_slot;
    logic [3:0][3:0] nxt_shadow;
    logic [BW-1:0]   nxt_blink_cnt;
    logic            nxt_blink_phase;
    logic [3:0]      digit;
    logic            blanked;
    logic            dark;
    logic [3:0]      nxt_an;
    logic [6:0]      nxt_seg;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // Next-state view: outputs are registered from the post-edge slot, shadows and blink phase
    always_comb begin
        tick     = (presc == PRESC_MAX);
        wrap     = (state == SCAN) && tick && (slot == 2'd3);
        capture  = tick && ((state == IDLE) || (slot == 2'd3));
        nxt_scan = (state == SCAN) || tick;

        nxt_slot = slot;
        if (state == IDLE) begin
            nxt_slot = 2'd0;
        end else if (tick) begin
            nxt_slot = slot + 2'd1;
        end

        nxt_shadow = shadow;
        if (capture) begin
            nxt_shadow = {bus.thousands, bus.hundreds, bus.tens, bus.ones};
        end

        // Holding the blink state at zero while disabled makes every blink start lit
        nxt_blink_cnt   = blink_cnt;
        nxt_blink_phase = blink_phase;
        if (!bus.blink_en) begin
            nxt_blink_cnt   = '0;
            nxt_blink_phase = 1'b0;
        end else if (wrap) begin
            if (blink_cnt == BLINK_MAX) begin
                nxt_blink_cnt   = '0;
                nxt_blink_phase = ~blink_phase;
            end else begin
                nxt_blink_cnt = blink_cnt + BW'(1);
            end
        end

        // Leading-zero chain: a slot is blank only if it and every higher digit is zero
        digit   = nxt_shadow[nxt_slot];
        blanked = 1'b0;
        if (bus.blank_lz) begin
            case (nxt_slot)
                2'd3:    blanked = (nxt_shadow[3] == 4'd0);
                2'd2:    blanked = (nxt_shadow[3] == 4'd0) && (nxt_shadow[2] == 4'd0);
                2'd1:    blanked = (nxt_shadow[3] == 4'd0) && (nxt_shadow[2] == 4'd0)
                                   && (nxt_shadow[1] == 4'd0);
                default: blanked = 1'b0;
            endcase
        end

        dark    = !nxt_scan || blanked || (bus.blink_en && nxt_blink_phase);
        nxt_an  = 4'b1111;
        nxt_seg = 7'b1111111;
        if (!dark) begin
            nxt_an  = ~(4'b0001 << nxt_slot);
            nxt_seg = seg_decode(digit);
        end
    end

    // Prescaler, scan FSM, frame capture, blink tracking and registered display outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            presc        <= '0;
            slot         <= 2'd0;
            shadow       <= '0;
            blink_cnt    <= '0;
            blink_phase  <= 1'b0;
            an_q         <= 4'b1111;
            seg_q        <= 7'b1111111;
            frame_done_q <= 1'b0;
        end else begin
            presc        <= tick ? '0 : presc + PW'(1);
            state        <= nxt_scan ? SCAN : IDLE;
            slot         <= nxt_slot;
            shadow       <= nxt_shadow;
            blink_cnt    <= nxt_blink_cnt;
            blink_phase  <= nxt_blink_phase;
            an_q         <= nxt_an;
            seg_q        <= nxt_seg;
            frame_done_q <= wrap;
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = 1'b1;
    assign bus.frame_done = frame_done_q;

endmodule
